spi_target: RTL and testbench

- SPI mode-0 responder (target) for the SPI bus that the system CPLD drives as initiator: SCLK, MOSI and chip select in, MISO out.
- Oversamples the bus with the 48 MHz master clock, shifts 8-bit frames MSB first, and exposes single-entry TX and RX holding registers with handshakes to local logic.
- Intended for peripheral-side CPLDs, and as a bus-functional endpoint for exercising the CPLD's bit-banged SD/SPI path.

---
 rtl/spi_target_if.sv | 28 ++
 rtl/spi_target.sv | 155 +++++++++++++++
 tb/tb_spi_target.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_target_if.sv
// Signal bundle for the SPI mode-0 target: initiator-facing pins plus the
// local TX/RX holding-register handshakes. The target side uses the slave modport.
interface spi_target_if;
  logic       SCLK;
  logic       MOSI;
  logic       nCS;
  logic       MISO;
  logic       MISO_OE;
  logic [7:0] TX_DATA;
  logic       TX_WR;
  logic       TX_EMPTY;
  logic       TX_UNDERRUN;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_ACK;
  logic       RX_OVERRUN;
  logic       BUSY;

  modport slave (
    input  SCLK, MOSI, nCS, TX_DATA, TX_WR, RX_ACK,
    output MISO, MISO_OE, TX_EMPTY, TX_UNDERRUN, RX_DATA, RX_VALID, RX_OVERRUN, BUSY
  );

  modport master (
    output SCLK, MOSI, nCS, TX_DATA, TX_WR, RX_ACK,
    input  MISO, MISO_OE, TX_EMPTY, TX_UNDERRUN, RX_DATA, RX_VALID, RX_OVERRUN, BUSY
  );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target oversampled by MHZ48: 8-bit MSB-first frames with
// single-entry TX/RX holding registers and sticky underrun/overrun flags.
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic        MHZ48,
  input  logic        RES,
  spi_target_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ncs_sync;
  logic                   r_sclk_d, r_ncs_d;

  state_t     r_state;
  logic [2:0] r_cnt;
  logic       r_reload;
  logic [7:0] r_tx_hold, r_shout, r_shin, r_rx_data;
  logic       r_tx_empty, r_tx_undr, r_rx_valid, r_rx_ovr;
  logic       r_miso, r_oe, r_busy;

  logic       w_sclk, w_ncs, w_mosi;
  logic       w_sclk_rise, w_sclk_fall, w_ncs_rise, w_ncs_fall;
  logic       w_active, w_load, w_shift, w_sample, w_done;
  logic       w_tx_accept, w_rx_accept;
  logic [7:0] w_load_byte, w_rx_byte;

  // Synchronisers reset to the bus idle levels so reset release creates no edge
  always_ff @(posedge MHZ48 or posedge RES) begin
    if (RES) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '1;
      r_ncs_sync  <= '1;
      r_sclk_d    <= 1'b0;
      r_ncs_d     <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], bus.nCS};
      r_sclk_d    <= w_sclk;
      r_ncs_d     <= w_ncs;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_ncs       = r_ncs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ncs_rise  = w_ncs & ~r_ncs_d;
  assign w_ncs_fall  = ~w_ncs & r_ncs_d;

  // Deselect overrides any SCLK event seen in the same cycle
  assign w_active    = (r_state == S_SHIFT) && !w_ncs_rise;
  assign w_load      = ((r_state == S_LOAD) && !w_ncs_rise) ||
                       (w_active && w_sclk_fall && r_reload);
  // Falling edges before the first rising edge of a frame are not shifts
  assign w_shift     = w_active && w_sclk_fall && !r_reload && (r_cnt != 3'd0);
  assign w_sample    = w_active && w_sclk_rise;
  assign w_done      = w_sample && (r_cnt == 3'd7);
  assign w_load_byte = r_tx_empty ? IDLE_BYTE : r_tx_hold;
  assign w_rx_byte   = {r_shin[6:0], w_mosi};
  assign w_tx_accept = bus.TX_WR && r_tx_empty;
  assign w_rx_accept = w_done && (!r_rx_valid || bus.RX_ACK);

  always_ff @(posedge MHZ48) begin
    if (w_tx_accept) r_tx_hold <= bus.TX_DATA;
    if (w_load)       r_shout <= w_load_byte;
    else if (w_shift) r_shout <= {r_shout[6:0], 1'b1};
    if (w_sample)     r_shin  <= w_rx_byte;
  end

  always_ff @(posedge MHZ48 or posedge RES) begin
    if (RES) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_reload   <= 1'b0;
      r_miso     <= 1'b1;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_empty <= 1'b1;
      r_tx_undr  <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
    end else begin
      // A write landing with an empty-register load is kept for the next frame
      if (w_tx_accept) begin
        r_tx_empty <= 1'b0;
        r_tx_undr  <= 1'b0;
      end
      if (w_load) begin
        r_miso <= w_load_byte[7];
        if (r_tx_empty) r_tx_undr  <= 1'b1;
        else            r_tx_empty <= 1'b1;
      end else if (w_shift) begin
        r_miso <= r_shout[6];
      end

      if (w_rx_accept) begin
        r_rx_data  <= w_rx_byte;
        r_rx_valid <= 1'b1;
      end else if (bus.RX_ACK) begin
        r_rx_valid <= 1'b0;
      end
      if (w_done && r_rx_valid && !bus.RX_ACK) r_rx_ovr <= 1'b1;
      else if (bus.RX_ACK)                     r_rx_ovr <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_oe     <= 1'b0;
          r_busy   <= 1'b0;
          r_cnt    <= 3'd0;
          r_reload <= 1'b0;
          if (w_ncs_fall) r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (w_ncs_rise) begin
            r_state <= S_IDLE;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_SHIFT;
            r_oe    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_ncs_rise) begin
            r_state  <= S_IDLE;
            r_oe     <= 1'b0;
            r_busy   <= 1'b0;
            r_cnt    <= 3'd0;
            r_reload <= 1'b0;
          end else begin
            if (w_sample) r_cnt <= r_cnt + 3'd1;
            if (w_done)   r_reload <= 1'b1;
            else if (w_sclk_fall) r_reload <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.MISO        = r_miso;
  assign bus.MISO_OE     = r_oe;
  assign bus.BUSY        = r_busy;
  assign bus.TX_EMPTY    = r_tx_empty;
  assign bus.TX_UNDERRUN = r_tx_undr;
  assign bus.RX_DATA     = r_rx_data;
  assign bus.RX_VALID    = r_rx_valid;
  assign bus.RX_OVERRUN  = r_rx_ovr;
endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a pin-level mode-0 initiator with a byte-level model
// of the holding registers, checked every settled cycle plus literal pins.
`timescale 1ns/1ps
module tb_spi_target;
  localparam int SS   = 2;
  localparam int HALF = 6;   // 6 MHZ48 cycles per SCLK phase = 4 MHz

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  spi_target_if bus();

  spi_target #(.SYNC_STAGES(SS), .IDLE_BYTE(8'hFF)) dut (
    .MHZ48 (clk),
    .RES   (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Byte-level model of the visible state
  logic [7:0] m_tx_hold  = 8'h00;
  logic       m_tx_empty = 1'b1;
  logic       m_undr     = 1'b0;
  logic [7:0] m_rx_data  = 8'h00;
  logic       m_rx_valid = 1'b0;
  logic       m_ovr      = 1'b0;
  logic       chk_en     = 1'b0;

  logic [7:0] mo        [0:3];
  logic [7:0] miso_seen [0:3];

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check1({tag, "_miso"},     bus.MISO,        1'b1);
    check1({tag, "_oe"},       bus.MISO_OE,     1'b0);
    check1({tag, "_tx_empty"}, bus.TX_EMPTY,    1'b1);
    check1({tag, "_undr"},     bus.TX_UNDERRUN, 1'b0);
    check8({tag, "_rx_data"},  bus.RX_DATA,     8'h00);
    check1({tag, "_rx_valid"}, bus.RX_VALID,    1'b0);
    check1({tag, "_ovr"},      bus.RX_OVERRUN,  1'b0);
    check1({tag, "_busy"},     bus.BUSY,        1'b0);
  endtask

  task automatic model_reset();
    m_tx_empty = 1'b1;
    m_undr     = 1'b0;
    m_rx_data  = 8'h00;
    m_rx_valid = 1'b0;
    m_ovr      = 1'b0;
  endtask

  task automatic model_load(output logic [7:0] b);
    if (!m_tx_empty) begin
      b = m_tx_hold;
      m_tx_empty = 1'b1;
    end else begin
      b = 8'hFF;
      m_undr = 1'b1;
    end
  endtask

  task automatic model_complete(input logic [7:0] b, input logic ack);
    if (!m_rx_valid || ack) begin
      m_rx_data  = b;
      m_rx_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
    if (ack) m_ovr = 1'b0;
  endtask

  // Settled-state compare, one sample per cycle away from the active edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (chk_en && !rst) begin
        check1("cyc_tx_empty", bus.TX_EMPTY,    m_tx_empty);
        check1("cyc_undr",     bus.TX_UNDERRUN, m_undr);
        check8("cyc_rx_data",  bus.RX_DATA,     m_rx_data);
        check1("cyc_rx_valid", bus.RX_VALID,    m_rx_valid);
        check1("cyc_ovr",      bus.RX_OVERRUN,  m_ovr);
        check1("cyc_busy",     bus.BUSY,        1'b0);
        check1("cyc_oe",       bus.MISO_OE,     1'b0);
      end
    end
  end

  task automatic tx_wr(input logic [7:0] d);
    @(negedge clk);
    bus.TX_DATA = d;
    bus.TX_WR   = 1'b1;
    if (m_tx_empty) begin
      m_tx_hold  = d;
      m_tx_empty = 1'b0;
      m_undr     = 1'b0;
    end
    @(negedge clk);
    bus.TX_WR = 1'b0;
  endtask

  task automatic rx_ack();
    @(negedge clk);
    bus.RX_ACK = 1'b1;
    m_rx_valid = 1'b0;
    m_ovr      = 1'b0;
    @(negedge clk);
    bus.RX_ACK = 1'b0;
  endtask

  // One select: nfull whole bytes from mo[], then pbits of a partial byte.
  // The final SCLK fall coincides with deselect, so no trailing reload occurs.
  task automatic frame(input int nfull, input int pbits, input logic ack_last);
    logic [7:0] exp_tx;
    logic [7:0] got;
    int nbytes;
    int nb;
    chk_en = 1'b0;
    nbytes = nfull + ((pbits > 0) ? 1 : 0);
    @(negedge clk);
    bus.nCS = 1'b0;
    repeat (8) @(negedge clk);
    model_load(exp_tx);
    for (int b = 0; b < nbytes; b++) begin
      nb  = (b < nfull) ? 8 : pbits;
      got = 8'h00;
      for (int i = 0; i < nb; i++) begin
        bus.MOSI = mo[b][7-i];
        repeat (HALF) @(negedge clk);
        check1("miso_bit", bus.MISO, exp_tx[7-i]);
        if (i == 0) check1("miso_oe_on", bus.MISO_OE, 1'b1);
        got[7-i] = bus.MISO;
        bus.SCLK = 1'b1;
        if (ack_last && (b == nfull - 1) && (i == 7)) begin
          repeat (SS) @(negedge clk);
          bus.RX_ACK = 1'b1;
          @(negedge clk);
          bus.RX_ACK = 1'b0;
          repeat (HALF - SS - 1) @(negedge clk);
        end else begin
          repeat (HALF) @(negedge clk);
        end
        if (!((b == nbytes - 1) && (i == nb - 1))) bus.SCLK = 1'b0;
      end
      miso_seen[b] = got;
      if (b < nfull) begin
        model_complete(mo[b], ack_last && (b == nfull - 1));
        if (b < nbytes - 1) model_load(exp_tx);
      end
    end
    bus.SCLK = 1'b0;
    bus.nCS  = 1'b1;
    repeat (SS + 2) @(posedge clk);
    #1;
    check1("deselect_oe", bus.MISO_OE, 1'b0);
    check1("deselect_busy", bus.BUSY, 1'b0);
    repeat (4) @(negedge clk);
    chk_en = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int nf;
    int pb;
    int op;
    bus.SCLK    = 1'b0;
    bus.MOSI    = 1'b1;
    bus.nCS     = 1'b1;
    bus.TX_DATA = 8'h00;
    bus.TX_WR   = 1'b0;
    bus.RX_ACK  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (4) @(negedge clk);

    // Single frame: A5 out, 3C in
    tx_wr(8'hA5);
    check1("lit_tx_empty_wr", bus.TX_EMPTY, 1'b0);
    mo[0] = 8'h3C;
    frame(1, 0, 1'b0);
    check8("lit_miso_a5", miso_seen[0], 8'hA5);
    check8("lit_rx_3c", bus.RX_DATA, 8'h3C);
    check1("lit_rx_valid_3c", bus.RX_VALID, 1'b1);
    check1("lit_tx_empty_after", bus.TX_EMPTY, 1'b1);
    check1("lit_no_undr", bus.TX_UNDERRUN, 1'b0);
    check1("lit_no_ovr", bus.RX_OVERRUN, 1'b0);
    rx_ack();

    // Underrun across back-to-back bytes
    mo[0] = 8'h12; mo[1] = 8'h34;
    frame(2, 0, 1'b0);
    check8("lit_miso_ff0", miso_seen[0], 8'hFF);
    check8("lit_miso_ff1", miso_seen[1], 8'hFF);
    check1("lit_undr_set", bus.TX_UNDERRUN, 1'b1);
    tx_wr(8'h01);
    check1("lit_undr_clr", bus.TX_UNDERRUN, 1'b0);
    rx_ack();

    // Overrun: 11 then 22 with no acknowledge
    mo[0] = 8'h11;
    frame(1, 0, 1'b0);
    check8("lit_miso_01", miso_seen[0], 8'h01);
    mo[0] = 8'h22;
    frame(1, 0, 1'b0);
    check8("lit_rx_11", bus.RX_DATA, 8'h11);
    check1("lit_ovr_set", bus.RX_OVERRUN, 1'b1);
    rx_ack();
    check1("lit_valid_clr", bus.RX_VALID, 1'b0);
    check1("lit_ovr_clr", bus.RX_OVERRUN, 1'b0);

    // Acknowledge in the completion cycle of 55 while 77 is still pending
    mo[0] = 8'h77;
    frame(1, 0, 1'b0);
    mo[0] = 8'h55;
    frame(1, 0, 1'b1);
    check8("lit_rx_55", bus.RX_DATA, 8'h55);
    check1("lit_valid_55", bus.RX_VALID, 1'b1);
    check1("lit_ovr_55", bus.RX_OVERRUN, 1'b0);
    rx_ack();

    // Abort after 5 bits, then a clean 99
    mo[0] = 8'hC3;
    frame(0, 5, 1'b0);
    check1("lit_abort_valid", bus.RX_VALID, 1'b0);
    check1("lit_abort_ovr", bus.RX_OVERRUN, 1'b0);
    mo[0] = 8'h99;
    frame(1, 0, 1'b0);
    check8("lit_rx_99", bus.RX_DATA, 8'h99);

    // Reset mid-frame after 3 bits
    tx_wr(8'h5A);
    chk_en = 1'b0;
    @(negedge clk);
    bus.nCS = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.MOSI = 1'($urandom);
      repeat (HALF) @(negedge clk);
      bus.SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.SCLK = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    bus.nCS = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.MOSI = 1'($urandom);
      bus.SCLK = ~bus.SCLK;
      repeat (HALF) @(negedge clk);
    end
    bus.SCLK = 1'b0;
    repeat (HALF) @(negedge clk);
    check1("lit_post_rst_valid", bus.RX_VALID, 1'b0);
    check1("lit_post_rst_busy", bus.BUSY, 1'b0);

    // Randomised traffic against the model
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 9));
      if (op < 3) begin
        tx_wr(8'($urandom));
      end else if (op < 5) begin
        rx_ack();
      end else begin
        nf = int'($urandom_range(0, 3));
        pb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
        if (nf == 0 && pb == 0) nf = 1;
        for (int k = 0; k < 4; k++) mo[k] = 8'($urandom);
        frame(nf, pb, (nf > 0) && ($urandom_range(0, 2) == 0));
      end
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
